// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped data-cache controller for the MEM stage, write-back or write-through
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   req_valid/write/addr/wdata       load/store request from the MEM stage
//   rdata, stall                     load data and pipeline freeze
//   mem_read/write/addr/wdata/wmask  line-wide memory command
//   mem_rdata                        fill line from memory
//   access_cnt, miss_cnt             saturating performance counters
module dcache_ctrl #(
    parameter int WORD_W      = 16,
    parameter int LINE_WORDS  = 4,
    parameter int SETS        = 4,
    parameter int MEM_LATENCY = 4,
    parameter int WRITE_BACK  = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         req_valid,
    input  logic                         req_write,
    input  logic [WORD_W-1:0]            req_addr,
    input  logic [WORD_W-1:0]            req_wdata,
    output logic [WORD_W-1:0]            rdata,
    output logic                         stall,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [WORD_W-1:0]            mem_addr,
    output logic [WORD_W*LINE_WORDS-1:0] mem_wdata,
    output logic [LINE_WORDS-1:0]        mem_wmask,
    input  logic [WORD_W*LINE_WORDS-1:0] mem_rdata,
    output logic [15:0]                  access_cnt,
    output logic [15:0]                  miss_cnt
);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = WORD_W - OFF_W - IDX_W;
    localparam int LINE_W  = WORD_W * LINE_WORDS;
    localparam int CNT_W   = $clog2(MEM_LATENCY + 1);
    localparam bit WB_MODE = (WRITE_BACK != 0);
    typedef enum logic [2:0] {IDLE, WB, FILL, WT, DONE} state_t;
    state_t state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] data [SETS];
    logic [TAG_W-1:0]  tags [SETS];
    logic [SETS-1:0]   valid, dirty;
    logic [WORD_W-1:0] laddr, lwdata;
    logic [OFF_W-1:0]  off, loff;
    logic [IDX_W-1:0]  idx, lidx;
    logic [TAG_W-1:0]  tag, ltag;
    logic              hit, lhit, wt_store, busy, last, wr_hit;
    assign off  = req_addr[OFF_W-1:0];
    assign idx  = req_addr[OFF_W +: IDX_W];
    assign tag  = req_addr[WORD_W-1 -: TAG_W];
    // the request is latched while idle so the transfer stays stable if the stage drops it
    assign loff = laddr[OFF_W-1:0];
    assign lidx = laddr[OFF_W +: IDX_W];
    assign ltag = laddr[WORD_W-1 -: TAG_W];
    assign hit      = req_valid && valid[idx] && tags[idx] == tag;
    assign lhit     = valid[lidx] && tags[lidx] == ltag;
    assign wt_store = !WB_MODE && req_write;
    assign busy     = state inside {WB, FILL, WT};
    assign last     = cnt == '0;
    assign wr_hit   = state == IDLE && hit && req_write && WB_MODE;
    assign stall = req_valid && (busy || (state == IDLE && (!hit || wt_store)));
    assign rdata = (state == IDLE && hit && !req_write) ? data[idx][off*WORD_W +: WORD_W] : '0;
    assign mem_read  = state == FILL;
    assign mem_write = state == WB || state == WT;
    assign mem_addr  = state == WB ? {tags[lidx], lidx, {OFF_W{1'b0}}} :
                       busy ? {ltag, lidx, {OFF_W{1'b0}}} : '0;
    assign mem_wdata = state == WB ? data[lidx] :
                       state == WT ? LINE_W'(lwdata) << (loff * WORD_W) : '0;
    assign mem_wmask = state == WB ? '1 :
                       state == WT ? LINE_WORDS'(1) << loff : '0;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid && (wt_store || !hit))
                         state_next = wt_store ? WT : (valid[idx] && dirty[idx]) ? WB : FILL;
            WB:      if (last) state_next = FILL;
            FILL:    if (last) state_next = IDLE;
            WT:      if (last) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            valid      <= '0;
            dirty      <= '0;
            laddr      <= '0;
            lwdata     <= '0;
            access_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state && state_next inside {WB, FILL, WT}) ?
                     CNT_W'(MEM_LATENCY - 1) : last ? cnt : cnt - 1'b1;
            if (state == IDLE) begin
                laddr  <= req_addr;
                lwdata <= req_wdata;
            end
            if (wr_hit) dirty[idx] <= 1'b1;
            if (state == FILL && last) begin
                valid[lidx] <= 1'b1;
                dirty[lidx] <= 1'b0;
            end
            if (req_valid && !stall && access_cnt != 16'hFFFF) access_cnt <= access_cnt + 1'b1;
            if (state == IDLE && req_valid && !hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_hit) data[idx][off*WORD_W +: WORD_W] <= req_wdata;
        if (state == FILL && last) begin
            data[lidx] <= mem_rdata;
            tags[lidx] <= ltag;
        end
        if (state == WT && last && lhit) data[lidx][loff*WORD_W +: WORD_W] <= lwdata;
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed checks of dcache_ctrl in write-back and write-through modes
module tb_dcache_ctrl;
    logic        clk = 0, reset_n = 0;
    logic        req_valid = 0, req_write = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic [15:0] rdata_wb, rdata_wt, mem_addr_wb, mem_addr_wt;
    logic        stall_wb, stall_wt, mem_read_wb, mem_read_wt, mem_write_wb, mem_write_wt;
    logic [63:0] mem_wdata_wb, mem_wdata_wt, mem_rdata_wb, mem_rdata_wt;
    logic [3:0]  mem_wmask_wb, mem_wmask_wt;
    logic [15:0] access_wb, access_wt, miss_wb, miss_wt;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    // memory model: word at address a holds a ^ 0xA500
    function automatic logic [63:0] line_of(input logic [15:0] a);
        logic [63:0] l;
        for (int i = 0; i < 4; i++) l[i*16 +: 16] = (a + 16'(i)) ^ 16'hA500;
        return l;
    endfunction
    assign mem_rdata_wb = line_of(mem_addr_wb);
    assign mem_rdata_wt = line_of(mem_addr_wt);
    dcache_ctrl #(.WRITE_BACK(1)) dut_wb (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata_wb), .stall(stall_wb),
        .mem_read(mem_read_wb), .mem_write(mem_write_wb), .mem_addr(mem_addr_wb),
        .mem_wdata(mem_wdata_wb), .mem_wmask(mem_wmask_wb), .mem_rdata(mem_rdata_wb),
        .access_cnt(access_wb), .miss_cnt(miss_wb));
    dcache_ctrl #(.WRITE_BACK(0)) dut_wt (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata_wt), .stall(stall_wt),
        .mem_read(mem_read_wt), .mem_write(mem_write_wt), .mem_addr(mem_addr_wt),
        .mem_wdata(mem_wdata_wt), .mem_wmask(mem_wmask_wt), .mem_rdata(mem_rdata_wt),
        .access_cnt(access_wt), .miss_cnt(miss_wt));
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    always @(negedge clk) if (reset_n) begin
        chk("excl_wb", 64'(mem_read_wb & mem_write_wb), 0);
        chk("excl_wt", 64'(mem_read_wt & mem_write_wt), 0);
    end
    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; req_valid = 0; req_write = 0;
        @(negedge clk);
        reset_n = 1;
    endtask
    task automatic xact(input bit sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int st, output int nr, output int nw, output logic [15:0] rd);
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        st = 0; nr = 0; nw = 0;
        #1;
        while ((sel ? stall_wt : stall_wb) && st < 100) begin
            st++;
            nr += int'(sel ? mem_read_wt : mem_read_wb);
            nw += int'(sel ? mem_write_wt : mem_write_wb);
            @(negedge clk);
            #1;
        end
        rd = sel ? rdata_wt : rdata_wb;
        @(posedge clk);
        #1;
        req_valid = 0; req_write = 0;
    endtask
    typedef struct {
        logic        w;
        logic [15:0] a, d;
        int          st;
        logic [15:0] rd;
        int          nr, nw;
    } vec_t;
    vec_t tbl[11];
    int st, nr, nw;
    logic [15:0] rd;
    initial begin
        tbl[0]  = '{1'b0, 16'h0012, 16'h0000, 5, 16'hA512, 4, 0};
        tbl[1]  = '{1'b0, 16'h0013, 16'h0000, 0, 16'hA513, 0, 0};
        tbl[2]  = '{1'b1, 16'h0012, 16'hBEEF, 0, 16'h0000, 0, 0};
        tbl[3]  = '{1'b0, 16'h0012, 16'h0000, 0, 16'hBEEF, 0, 0};
        tbl[4]  = '{1'b0, 16'h0052, 16'h0000, 9, 16'hA552, 4, 4};
        tbl[5]  = '{1'b0, 16'h0012, 16'h0000, 5, 16'hA512, 4, 0};
        tbl[6]  = '{1'b0, 16'h0025, 16'h0000, 5, 16'hA525, 4, 0};
        tbl[7]  = '{1'b1, 16'h0036, 16'h1111, 5, 16'h0000, 4, 0};
        tbl[8]  = '{1'b0, 16'h0036, 16'h0000, 0, 16'h1111, 0, 0};
        tbl[9]  = '{1'b0, 16'h0026, 16'h0000, 9, 16'hA526, 4, 4};
        tbl[10] = '{1'b0, 16'h00FF, 16'h0000, 5, 16'hA5FF, 4, 0};
        repeat (2) @(negedge clk);
        reset_n = 1;
        #1;
        chk("rst_stall", 64'(stall_wb), 0);
        chk("rst_mem_cmd", 64'({mem_read_wb, mem_write_wb, mem_read_wt, mem_write_wt}), 0);
        chk("rst_mem_addr", 64'(mem_addr_wb), 0);
        chk("rst_mem_wdata", mem_wdata_wb, 0);
        chk("rst_mem_wmask", 64'(mem_wmask_wb), 0);
        chk("rst_rdata", 64'(rdata_wb), 0);
        chk("rst_counters", 64'({access_wb, miss_wb}), 0);
        for (int i = 0; i < 11; i++) begin
            xact(0, tbl[i].w, tbl[i].a, tbl[i].d, st, nr, nw, rd);
            chk($sformatf("vec%0d_stall_cycles", i), 64'(st), 64'(tbl[i].st));
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(tbl[i].rd));
            chk($sformatf("vec%0d_read_cycles", i), 64'(nr), 64'(tbl[i].nr));
            chk($sformatf("vec%0d_write_cycles", i), 64'(nw), 64'(tbl[i].nw));
        end
        chk("tbl_miss_cnt", 64'(miss_wb), 7);
        chk("tbl_access_cnt", 64'(access_wb), 11);
        // dirty victim write-back followed by fill
        do_reset();
        xact(0, 0, 16'h0012, 0, st, nr, nw, rd);
        xact(0, 1, 16'h0012, 16'hBEEF, st, nr, nw, rd);
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 16'h0052;
        #1;
        chk("wb_detect_stall", 64'(stall_wb), 1);
        chk("wb_detect_nocmd", 64'(mem_write_wb), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("wb_cmd", 64'({mem_write_wb, mem_read_wb, stall_wb}), 64'b101);
            chk("wb_addr", 64'(mem_addr_wb), 16'h0010);
            chk("wb_mask", 64'(mem_wmask_wb), 4'b1111);
            chk("wb_word2", 64'(mem_wdata_wb[47:32]), 16'hBEEF);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("fill_cmd", 64'({mem_write_wb, mem_read_wb, stall_wb}), 64'b011);
            chk("fill_addr", 64'(mem_addr_wb), 16'h0050);
        end
        @(negedge clk);
        #1;
        chk("wb_after_stall", 64'(stall_wb), 0);
        chk("wb_after_rdata", 64'(rdata_wb), 16'hA552);
        @(posedge clk);
        #1;
        req_valid = 0;
        chk("wb_miss_cnt", 64'(miss_wb), 2);
        chk("wb_access_cnt", 64'(access_wb), 3);
        // write-through store miss, no allocation
        do_reset();
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 16'h0021; req_wdata = 16'h1234;
        #1;
        chk("wt_detect_stall", 64'(stall_wt), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("wt_cmd", 64'({mem_write_wt, mem_read_wt, stall_wt}), 64'b101);
            chk("wt_addr", 64'(mem_addr_wt), 16'h0020);
            chk("wt_mask", 64'(mem_wmask_wt), 4'b0010);
            chk("wt_word1", 64'(mem_wdata_wt[31:16]), 16'h1234);
        end
        @(negedge clk);
        #1;
        chk("wt_done_stall", 64'(stall_wt), 0);
        chk("wt_done_nocmd", 64'(mem_write_wt), 0);
        @(posedge clk);
        #1;
        req_valid = 0; req_write = 0;
        xact(1, 0, 16'h0021, 0, st, nr, nw, rd);
        chk("wt_load_miss_stall", 64'(st), 5);
        chk("wt_load_rdata", 64'(rd), 16'hA521);
        xact(1, 1, 16'h0021, 16'h5555, st, nr, nw, rd);
        chk("wt_store_hit_stall", 64'(st), 5);
        chk("wt_store_hit_writes", 64'(nw), 4);
        xact(1, 0, 16'h0021, 0, st, nr, nw, rd);
        chk("wt_reload_stall", 64'(st), 0);
        chk("wt_reload_rdata", 64'(rd), 16'h5555);
        chk("wt_miss_cnt", 64'(miss_wt), 2);
        chk("wt_access_cnt", 64'(access_wt), 4);
        // reset during the second FILL cycle
        do_reset();
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 16'h0012;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("fill2_read", 64'(mem_read_wb), 1);
        reset_n = 0; req_valid = 0;
        #1;
        chk("rstmid_read", 64'(mem_read_wb), 0);
        chk("rstmid_addr", 64'(mem_addr_wb), 0);
        chk("rstmid_stall", 64'(stall_wb), 0);
        chk("rstmid_counters", 64'({access_wb, miss_wb}), 0);
        @(negedge clk);
        reset_n = 1;
        xact(0, 0, 16'h0012, 0, st, nr, nw, rd);
        chk("rstmid_remiss_stall", 64'(st), 5);
        chk("rstmid_remiss_rdata", 64'(rd), 16'hA512);
        // access counter saturation
        do_reset();
        xact(0, 0, 16'h0012, 0, st, nr, nw, rd);
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 16'h0013;
        repeat (16'hFFFD) @(posedge clk);
        #1;
        chk("sat_fffe", 64'(access_wb), 16'hFFFE);
        @(posedge clk);
        #1;
        chk("sat_ffff", 64'(access_wb), 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", 64'(access_wb), 16'hFFFF);
        chk("sat_miss_cnt", 64'(miss_wb), 1);
        req_valid = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
